constellation_dot_scheduler: RTL and testbench
==============================================

Name: constellation_dot_scheduler

Overview:
Frame-synchronous arbiter and write sequencer for the constellation dot store in the clk_pixel domain.
- Accepts symbols from N_REQ sources (e.g. raw RX, post-equaliser, reference constellation) over valid/ready.
- Round-robin arbitrates between sources, converts Q1.11 I/Q to clamped pixel coordinates and writes them into the DEPTH-entry dot store.
- Clears the store at each frame start and supports a freeze (persistence-hold) mode.

Parameters:
- N_REQ, 3, number of symbol sources.
- DEPTH, 64, dot store entries; power of two; AW = log2(DEPTH).
- SHIFT, 3, arithmetic right shift applied to I/Q before pixel mapping.
- CENTER_X, 640, pixel X of I=0.
- CENTER_Y, 360, pixel Y of Q=0.
- X_MIN / X_MAX, 320 / 959, horizontal plot clamp bounds.
- Y_MIN / Y_MAX, 40 / 679, vertical plot clamp bounds.

Ports:
- clk_pixel  in  1  74.25 MHz pixel clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- frame_start  in  1  single-cycle pulse at vsync rising edge.
- freeze  in  1  level; 1 = hold current dots, accept nothing.
- req_valid  in  N_REQ  per-source symbol valid.
- req_ready  out  N_REQ  per-source grant; at most one bit set.
- req_I  in  N_REQ*12  packed signed Q1.11 I; source k occupies [12k+11:12k].
- req_Q  in  N_REQ*12  packed signed Q1.11 Q; same packing as req_I.
- wr_en  out  1  dot store write strobe.
- wr_clear  out  1  with wr_en: invalidate entry; otherwise write a valid dot.
- wr_addr  out  AW  dot store address.
- wr_x  out  12  pixel X.
- wr_y  out  11  pixel Y.
- wr_src  out  2  source index, used by the renderer for colour.
- frame_dots  out  AW+1  dots written this frame.
- busy  out  1  clear sweep in progress.

Behaviour:
- States: CLEAR, RUN, FULL, HOLD.
- Reset values:
  - All outputs 0 except busy = 1.
  - Internal state: state = CLEAR, sweep address = 0, write pointer = 0, round-robin pointer = 0.
  - Reset asserted mid-sweep or mid-write aborts immediately.
- CLEAR:
  - One entry per cycle: wr_en = 1, wr_clear = 1, wr_addr = 0..DEPTH-1 in order; busy = 1; req_ready = 0.
  - After address DEPTH-1 go to RUN (freeze = 0) or HOLD (freeze = 1).
  - frame_dots = 0 throughout.
- RUN:
  - Grant: req_ready is a one-hot, combinational grant to the first valid source at or after the round-robin pointer.
  - A transfer occurs when valid and ready are both high. The pointer then moves to (granted + 1) mod N_REQ.
  - The cycle after a transfer: wr_en = 1, wr_clear = 0, wr_addr = write pointer, wr_x/wr_y/wr_src registered. Latency is 1 cycle.
  - The write pointer and frame_dots increment on each accepted symbol.
  - When the DEPTH-th symbol is accepted, go to FULL.
  - At most one symbol is accepted per cycle.
- FULL: req_ready = 0; wr_en = 0. The final write still issues on the cycle after the last accept.
- HOLD:
  - Entered from RUN or FULL whenever freeze = 1.
  - req_ready = 0; no writes.
  - frame_start is ignored, so dots persist.
  - freeze = 0 returns to RUN if frame_dots < DEPTH, otherwise to FULL.
- frame_start in RUN or FULL (freeze = 0): go to CLEAR; sweep, write pointer and frame_dots restart from 0. No grant in that cycle.
- frame_start during CLEAR: restart the sweep at address 0.
- frame_start and freeze high in the same cycle: freeze wins (HOLD).
- Coordinate mapping:
  - x = CENTER_X + (sign-extended I >>> SHIFT); y = CENTER_Y − (Q >>> SHIFT).
  - Computed in 14-bit signed, then clamped to [X_MIN, X_MAX] and [Y_MIN, Y_MAX].
- A source holding valid while not granted keeps its data stable. No combinational path from req_valid to wr_* outputs.

Optional Feature:
- Macro: GDSP_SCHED_DECIM_EN.
- When defined:
  - Extra input decim_log2 (3 bits) and one per-source counter.
  - A source's accepted symbol is written only when its counter is 0. Decimated symbols are still handshaken (ready pulses) but cause no write and no frame_dots increment.
  - The counter wraps at 2^decim_log2 and resets to 0 on frame_start.
- When not defined: the port is absent and every accepted symbol is written.

Test Plan:
- Release reset, no requests -> 64 cycles of wr_en = wr_clear = 1, addr 0..63, busy = 1; then busy = 0, req_ready = 0.
- All 3 sources valid continuously -> grants cycle 0,1,2,0,…; wr_src matches; wr_addr 0,1,2,… one cycle after each grant.
- Source 0 only valid, I = 0x000, Q = 0x000 -> wr_x = 640, wr_y = 360. I = 0x7FF -> x = 895. I = 0x800 (SHIFT=2) -> x clamped 320. Q = 0x800 (SHIFT=2) -> y = 679.
- 70 symbols offered within one frame -> exactly 64 writes, frame_dots = 64, req_ready = 0 afterwards. frame_start -> CLEAR sweep, frame_dots = 0, grants resume.
- freeze = 1 after 10 dots, then two frame_start pulses -> no clear, no writes, frame_dots stays 10. freeze = 0 -> grants resume at wr_addr 10.
- frame_start pulse at sweep address 30 -> sweep restarts at 0 and completes 64 entries. rst asserted mid-RUN -> outputs 0, busy = 1, sweep from 0 after release.

Source files
------------

// File: rtl/constellation_dot_scheduler.sv
// constellation_dot_scheduler
// Round-robin arbiter and write sequencer for the constellation dot store
// (clk_pixel domain). Sweeps the store clear at every frame start, then
// accepts one symbol per cycle from N_REQ sources, maps Q1.11 I/Q to clamped
// pixel coordinates and issues one registered store write per accepted
// symbol. A freeze level holds the current dots across frames.
// Optional build macro GDSP_SCHED_DECIM_EN adds decim_log2 and per-source
// decimation: accepted symbols are only written when the source's counter
// is zero.
// The source index is carried in 2 bits (wr_src), so N_REQ is at most 4.
module constellation_dot_scheduler #(
    parameter int N_REQ    = 3,
    parameter int DEPTH    = 64,
    parameter int SHIFT    = 3,
    parameter int CENTER_X = 640,
    parameter int CENTER_Y = 360,
    parameter int X_MIN    = 320,
    parameter int X_MAX    = 959,
    parameter int Y_MIN    = 40,
    parameter int Y_MAX    = 679,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                clk_pixel,
    input  logic                rst,
    input  logic                frame_start,
    input  logic                freeze,
`ifdef GDSP_SCHED_DECIM_EN
    input  logic [2:0]          decim_log2,
`endif
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ*12-1:0] req_I,
    input  logic [N_REQ*12-1:0] req_Q,
    output logic                wr_en,
    output logic                wr_clear,
    output logic [AW-1:0]       wr_addr,
    output logic [11:0]         wr_x,
    output logic [10:0]         wr_y,
    output logic [1:0]          wr_src,
    output logic [AW:0]         frame_dots,
    output logic                busy
);

    localparam int FW = AW + 1;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_FULL  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] sweep_q, sweep_d;
    logic [AW-1:0] wp_q, wp_d;
    logic [1:0]    rr_q, rr_d;
    logic [FW-1:0] frame_dots_q, frame_dots_d;
    logic          wr_en_q, wr_en_d;
    logic          wr_clear_q, wr_clear_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [11:0]   wr_x_q, wr_x_d;
    logic [10:0]   wr_y_q, wr_y_d;
    logic [1:0]    wr_src_q, wr_src_d;
    logic          busy_q, busy_d;
    logic          arb_found_s;
    logic [1:0]    arb_idx_s;
    logic          write_ok_s;
`ifdef GDSP_SCHED_DECIM_EN
    logic [6:0]    dcnt_q [N_REQ];
    logic [6:0]    dcnt_d [N_REQ];
    logic [6:0]    dmask_s;
    assign dmask_s = 7'((8'd1 << decim_log2) - 8'd1);
`endif

    // I -> pixel X: centre offset plus shifted sample, clamped to the plot
    function automatic logic [11:0] map_x(input logic [11:0] iv);
        logic signed [13:0] v;
        v = $signed(14'(CENTER_X)) + ($signed({{2{iv[11]}}, iv}) >>> SHIFT);
        if (v < $signed(14'(X_MIN))) begin
            map_x = 12'(X_MIN);
        end else if (v > $signed(14'(X_MAX))) begin
            map_x = 12'(X_MAX);
        end else begin
            map_x = v[11:0];
        end
    endfunction

    // Q -> pixel Y: screen Y grows downward, so positive Q moves up
    function automatic logic [10:0] map_y(input logic [11:0] qv);
        logic signed [13:0] v;
        v = $signed(14'(CENTER_Y)) - ($signed({{2{qv[11]}}, qv}) >>> SHIFT);
        if (v < $signed(14'(Y_MIN))) begin
            map_y = 11'(Y_MIN);
        end else if (v > $signed(14'(Y_MAX))) begin
            map_y = 11'(Y_MAX);
        end else begin
            map_y = v[10:0];
        end
    endfunction

    // Round-robin search: first valid source at or after the pointer
    always_comb begin
        logic [2:0] cand;
        cand        = 3'd0;
        arb_found_s = 1'b0;
        arb_idx_s   = 2'd0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_q} + 3'(k);
            if (cand >= 3'(N_REQ)) begin
                cand = cand - 3'(N_REQ);
            end else begin
                cand = cand;
            end
            if (!arb_found_s && req_valid[cand[1:0]]) begin
                arb_found_s = 1'b1;
                arb_idx_s   = cand[1:0];
            end else begin
                arb_found_s = arb_found_s;
            end
        end
    end

    // Next-state, grant and store-write decode
    always_comb begin
        state_d      = state_q;
        sweep_d      = sweep_q;
        wp_d         = wp_q;
        rr_d         = rr_q;
        frame_dots_d = frame_dots_q;
        wr_en_d      = 1'b0;
        wr_clear_d   = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_x_d       = wr_x_q;
        wr_y_d       = wr_y_q;
        wr_src_d     = wr_src_q;
        busy_d       = 1'b0;
        req_ready    = '0;
        write_ok_s   = 1'b1;
`ifdef GDSP_SCHED_DECIM_EN
        dcnt_d       = dcnt_q;
`endif
        case (state_q)
            ST_CLEAR: begin
                busy_d       = 1'b1;
                wr_en_d      = 1'b1;
                wr_clear_d   = 1'b1;
                wp_d         = '0;
                frame_dots_d = '0;
                if (frame_start) begin
                    // a new frame restarts the sweep; entry 0 is cleared now
                    wr_addr_d = '0;
                    sweep_d   = AW'(1);
                end else begin
                    wr_addr_d = sweep_q;
                    sweep_d   = sweep_q + AW'(1);
                    if (sweep_q == AW'(DEPTH - 1)) begin
                        state_d = freeze ? ST_HOLD : ST_RUN;
                    end else begin
                        state_d = ST_CLEAR;
                    end
                end
            end
            ST_RUN, ST_FULL: begin
                if (freeze) begin
                    state_d = ST_HOLD;
                end else if (frame_start) begin
                    state_d      = ST_CLEAR;
                    sweep_d      = '0;
                    wp_d         = '0;
                    frame_dots_d = '0;
                end else if ((state_q == ST_RUN) && arb_found_s) begin
                    req_ready[arb_idx_s] = 1'b1;
                    rr_d = (arb_idx_s == 2'(N_REQ - 1)) ? 2'd0 : arb_idx_s + 2'd1;
`ifdef GDSP_SCHED_DECIM_EN
                    write_ok_s        = (dcnt_q[arb_idx_s] == 7'd0);
                    dcnt_d[arb_idx_s] = (dcnt_q[arb_idx_s] + 7'd1) & dmask_s;
`endif
                    if (write_ok_s) begin
                        wr_en_d      = 1'b1;
                        wr_addr_d    = wp_q;
                        wr_x_d       = map_x(req_I[12*arb_idx_s +: 12]);
                        wr_y_d       = map_y(req_Q[12*arb_idx_s +: 12]);
                        wr_src_d     = arb_idx_s;
                        wp_d         = wp_q + AW'(1);
                        frame_dots_d = frame_dots_q + FW'(1);
                        if (frame_dots_q == FW'(DEPTH - 1)) begin
                            state_d = ST_FULL;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_HOLD: begin
                if (!freeze) begin
                    state_d = (frame_dots_q == FW'(DEPTH)) ? ST_FULL : ST_RUN;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                sweep_d = '0;
            end
        endcase
`ifdef GDSP_SCHED_DECIM_EN
        if (frame_start) begin
            for (int k = 0; k < N_REQ; k++) begin
                dcnt_d[k] = 7'd0;
            end
        end else begin
            dcnt_d = dcnt_d;
        end
`endif
    end

    // State, pointers and registered store-write outputs
    always_ff @(posedge clk_pixel or posedge rst) begin
        if (rst) begin
            state_q      <= ST_CLEAR;
            sweep_q      <= '0;
            wp_q         <= '0;
            rr_q         <= 2'd0;
            frame_dots_q <= '0;
            wr_en_q      <= 1'b0;
            wr_clear_q   <= 1'b0;
            wr_addr_q    <= '0;
            wr_x_q       <= 12'd0;
            wr_y_q       <= 11'd0;
            wr_src_q     <= 2'd0;
            busy_q       <= 1'b1;
`ifdef GDSP_SCHED_DECIM_EN
            for (int k = 0; k < N_REQ; k++) begin
                dcnt_q[k] <= 7'd0;
            end
`endif
        end else begin
            state_q      <= state_d;
            sweep_q      <= sweep_d;
            wp_q         <= wp_d;
            rr_q         <= rr_d;
            frame_dots_q <= frame_dots_d;
            wr_en_q      <= wr_en_d;
            wr_clear_q   <= wr_clear_d;
            wr_addr_q    <= wr_addr_d;
            wr_x_q       <= wr_x_d;
            wr_y_q       <= wr_y_d;
            wr_src_q     <= wr_src_d;
            busy_q       <= busy_d;
`ifdef GDSP_SCHED_DECIM_EN
            dcnt_q       <= dcnt_d;
`endif
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_clear   = wr_clear_q;
    assign wr_addr    = wr_addr_q;
    assign wr_x       = wr_x_q;
    assign wr_y       = wr_y_q;
    assign wr_src     = wr_src_q;
    assign frame_dots = frame_dots_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_constellation_dot_scheduler.sv
// Self-checking bench for constellation_dot_scheduler (default build).
// Reference model: abstract round-robin pointer, dot count and arithmetic
// coordinate mapping. DUT built with SHIFT = 2 so the clamp bounds are hit.
module tb_constellation_dot_scheduler;

    localparam int NR = 3;
    localparam int DP = 64;
    localparam int SH = 2;

    logic        clk_pixel = 1'b0;
    logic        rst;
    logic        frame_start;
    logic        freeze;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [35:0] req_I;
    logic [35:0] req_Q;
    logic        wr_en;
    logic        wr_clear;
    logic [5:0]  wr_addr;
    logic [11:0] wr_x;
    logic [10:0] wr_y;
    logic [1:0]  wr_src;
    logic [6:0]  frame_dots;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    int m_rr     = 0;
    int m_dots   = 0;
    logic [11:0] src_I [NR];
    logic [11:0] src_Q [NR];

    always #5 clk_pixel = ~clk_pixel;

    assign req_I = {src_I[2], src_I[1], src_I[0]};
    assign req_Q = {src_Q[2], src_Q[1], src_Q[0]};

    constellation_dot_scheduler #(.SHIFT(SH)) dut (
        .clk_pixel  (clk_pixel),
        .rst        (rst),
        .frame_start(frame_start),
        .freeze     (freeze),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_I      (req_I),
        .req_Q      (req_Q),
        .wr_en      (wr_en),
        .wr_clear   (wr_clear),
        .wr_addr    (wr_addr),
        .wr_x       (wr_x),
        .wr_y       (wr_y),
        .wr_src     (wr_src),
        .frame_dots (frame_dots),
        .busy       (busy)
    );

    function automatic int sx(input logic [11:0] v);
        return v[11] ? int'(v) - 4096 : int'(v);
    endfunction

    function automatic int ref_x(input logic [11:0] iv);
        int x;
        x = 640 + (sx(iv) >>> SH);
        if (x < 320) x = 320;
        if (x > 959) x = 959;
        return x;
    endfunction

    function automatic int ref_y(input logic [11:0] qv);
        int y;
        y = 360 - (sx(qv) >>> SH);
        if (y < 40) y = 40;
        if (y > 679) y = 679;
        return y;
    endfunction

    // One RUN-mode cycle: drive valids, check the grant, check the write
    task automatic run_cycle(input logic [2:0] vmask);
        int g, ex, ey, ea;
        logic [2:0] er;
        req_valid = vmask;
        frame_start = 1'b0;
        freeze = 1'b0;
        #1;
        g = -1; ex = 0; ey = 0; ea = 0;
        if (m_dots < DP) begin
            for (int i = 0; i < NR; i++) begin
                if (g < 0 && vmask[(m_rr + i) % NR]) g = (m_rr + i) % NR;
            end
        end
        er = (g >= 0) ? 3'(1 << g) : 3'b000;
        n_checks++;
        if (req_ready !== er) $display("FAIL run.ready got %b want %b", req_ready, er);
        else n_pass++;
        if (g >= 0) begin
            ex = ref_x(src_I[g]);
            ey = ref_y(src_Q[g]);
            ea = m_dots;
            m_dots++;
            m_rr = (g + 1) % NR;
        end
        @(posedge clk_pixel); #2;
        if (g >= 0) begin
            src_I[g] = 12'($urandom);
            src_Q[g] = 12'($urandom);
        end
        n_checks++;
        if (wr_en !== (g >= 0)) $display("FAIL run.wr_en got %b want %b", wr_en, (g >= 0));
        else n_pass++;
        if (g >= 0) begin
            n_checks++;
            if (wr_clear !== 1'b0 || wr_addr !== 6'(ea) || wr_src !== 2'(g))
                $display("FAIL run.write got clr=%b addr=%0d src=%0d want clr=0 addr=%0d src=%0d",
                         wr_clear, wr_addr, wr_src, ea, g);
            else n_pass++;
            n_checks++;
            if (wr_x !== 12'(ex) || wr_y !== 11'(ey))
                $display("FAIL run.xy got x=%0d y=%0d want x=%0d y=%0d", wr_x, wr_y, ex, ey);
            else n_pass++;
        end
        n_checks++;
        if (frame_dots !== 7'(m_dots) || busy !== 1'b0)
            $display("FAIL run.dots got dots=%0d busy=%b want dots=%0d busy=0", frame_dots, busy, m_dots);
        else n_pass++;
    endtask

    // Clear-sweep entries first..last, one per cycle
    task automatic sweep_check(input int first, input int last);
        for (int a = first; a <= last; a++) begin
            @(posedge clk_pixel); #2;
            n_checks++;
            if (wr_en !== 1'b1 || wr_clear !== 1'b1 || wr_addr !== 6'(a) || busy !== 1'b1 || frame_dots !== 7'd0)
                $display("FAIL sweep got en=%b clr=%b addr=%0d busy=%b dots=%0d want en=1 clr=1 addr=%0d busy=1 dots=0",
                         wr_en, wr_clear, wr_addr, busy, frame_dots, a);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        req_valid = 3'b111;
        #1;
        n_checks++;
        if (wr_en !== 1'b0 || wr_clear !== 1'b0 || wr_addr !== 6'd0 || wr_x !== 12'd0 ||
            wr_y !== 11'd0 || wr_src !== 2'd0 || frame_dots !== 7'd0 || busy !== 1'b1 || req_ready !== 3'b000)
            $display("FAIL reset.outputs got en=%b clr=%b addr=%0d x=%0d y=%0d src=%0d dots=%0d busy=%b rdy=%b want zeros busy=1",
                     wr_en, wr_clear, wr_addr, wr_x, wr_y, wr_src, frame_dots, busy, req_ready);
        else n_pass++;
        req_valid = 3'b000;
        rst = 1'b0;
        m_rr = 0; m_dots = 0;
        sweep_check(0, DP - 1);
        run_cycle(3'b000);
    endtask

    task automatic test_round_robin();
        for (int c = 0; c < 9; c++) run_cycle(3'b111);
    endtask

    task automatic test_random();
        for (int c = 0; c < 20; c++) run_cycle(3'($urandom_range(0, 7)));
    endtask

    task automatic test_mapping();
        logic [11:0] ti [6];
        logic [11:0] tq [6];
        ti[0] = 12'h000; tq[0] = 12'h000;
        ti[1] = 12'h7FF; tq[1] = 12'h000;
        ti[2] = 12'h800; tq[2] = 12'h000;
        ti[3] = 12'h000; tq[3] = 12'h800;
        ti[4] = 12'h000; tq[4] = 12'h7FF;
        ti[5] = 12'h100; tq[5] = 12'hF00;
        for (int k = 0; k < 6; k++) begin
            src_I[0] = ti[k];
            src_Q[0] = tq[k];
            run_cycle(3'b001);
        end
    endtask

    task automatic frame_pulse_from_run();
        frame_start = 1'b1;
        req_valid = 3'b111;
        #1;
        n_checks++;
        if (req_ready !== 3'b000) $display("FAIL frame.ready got %b want 000", req_ready);
        else n_pass++;
        @(posedge clk_pixel); #2;
        frame_start = 1'b0;
        req_valid = 3'b000;
        m_dots = 0;
        n_checks++;
        if (wr_en !== 1'b0 || frame_dots !== 7'd0)
            $display("FAIL frame.enter got en=%b dots=%0d want en=0 dots=0", wr_en, frame_dots);
        else n_pass++;
    endtask

    task automatic test_full();
        for (int c = 0; c < 80 && m_dots < DP; c++) run_cycle(3'b111);
        for (int c = 0; c < 6; c++) run_cycle(3'b111);
        frame_pulse_from_run();
        sweep_check(0, DP - 1);
        for (int c = 0; c < 3; c++) run_cycle(3'b111);
    endtask

    task automatic test_freeze();
        logic [4:0] fs_pat;
        fs_pat = 5'b01010;
        for (int c = 0; c < 80 && m_dots < 10; c++) run_cycle(3'($urandom_range(1, 7)));
        for (int c = 0; c < 5; c++) begin
            freeze = 1'b1;
            frame_start = fs_pat[c];
            req_valid = 3'b111;
            #1;
            n_checks++;
            if (req_ready !== 3'b000) $display("FAIL freeze.ready got %b want 000", req_ready);
            else n_pass++;
            @(posedge clk_pixel); #2;
            n_checks++;
            if (wr_en !== 1'b0 || busy !== 1'b0 || frame_dots !== 7'(m_dots))
                $display("FAIL freeze.hold got en=%b busy=%b dots=%0d want en=0 busy=0 dots=%0d",
                         wr_en, busy, frame_dots, m_dots);
            else n_pass++;
        end
        freeze = 1'b0;
        frame_start = 1'b0;
        req_valid = 3'b000;
        @(posedge clk_pixel); #2;
        n_checks++;
        if (wr_en !== 1'b0) $display("FAIL freeze.release got en=%b want 0", wr_en);
        else n_pass++;
        for (int c = 0; c < 3; c++) run_cycle(3'b111);
    endtask

    task automatic test_clear_restart();
        frame_pulse_from_run();
        sweep_check(0, 29);
        frame_start = 1'b1;
        sweep_check(0, 0);
        frame_start = 1'b0;
        sweep_check(1, DP - 1);
        for (int c = 0; c < 2; c++) run_cycle(3'b111);
    endtask

    task automatic test_reset_midrun();
        for (int c = 0; c < 3; c++) run_cycle(3'b111);
        req_valid = 3'b111;
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (wr_en !== 1'b0 || wr_clear !== 1'b0 || wr_addr !== 6'd0 || frame_dots !== 7'd0 ||
            busy !== 1'b1 || req_ready !== 3'b000)
            $display("FAIL midreset got en=%b clr=%b addr=%0d dots=%0d busy=%b rdy=%b want zeros busy=1",
                     wr_en, wr_clear, wr_addr, frame_dots, busy, req_ready);
        else n_pass++;
        @(posedge clk_pixel); #2;
        req_valid = 3'b000;
        rst = 1'b0;
        m_rr = 0; m_dots = 0;
        sweep_check(0, DP - 1);
        for (int c = 0; c < 3; c++) run_cycle(3'b111);
    endtask

    initial begin
        rst = 1'b1;
        frame_start = 1'b0;
        freeze = 1'b0;
        req_valid = 3'b000;
        for (int k = 0; k < NR; k++) begin
            src_I[k] = 12'($urandom);
            src_Q[k] = 12'($urandom);
        end
        repeat (2) @(posedge clk_pixel);
        #2;
        test_reset();
        test_round_robin();
        test_random();
        test_mapping();
        test_full();
        test_freeze();
        test_clear_restart();
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
